alu_issue: RTL



---
 rtl/alu_issue_if.sv | 25 ++
 rtl/alu_issue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Operand/control handshake bundle between register read, the issue buffer and the ALU.
interface alu_issue_if;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rega;
  logic [31:0] regb;
  logic [3:0]  alu_ctrl_s;
  logic [4:0]  dest;
  logic        illegal;

  modport slave (
    input  instr, rs_data, rt_data, in_valid, out_ready,
    output in_ready, out_valid, rega, regb, alu_ctrl_s, dest, illegal
  );

  modport master (
    output instr, rs_data, rt_data, in_valid, out_ready,
    input  in_ready, out_valid, rega, regb, alu_ctrl_s, dest, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Decodes MIPS R/I-type ALU instructions into opcode + operands and buffers
// the result in a 2-entry valid/ready FIFO feeding the execute stage.
module alu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  localparam logic [1:0] FullCount = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] rega;
    logic [31:0] regb;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic        illegal;
  } payload_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] immSext;
  logic [31:0] immZext;
  logic        unusedBits;

  assign opcode     = bus.instr[31:26];
  assign funct      = bus.instr[5:0];
  assign shamt      = bus.instr[10:6];
  assign immSext    = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign immZext    = {16'b0, bus.instr[15:0]};
  assign unusedBits = ^bus.instr[25:21];

  payload_t decoded;
  logic     decLegal;
  logic     shamtSel;
  logic     isLui;

  always_comb begin
    decoded  = '0;
    decLegal = 1'b0;
    shamtSel = 1'b0;
    isLui    = 1'b0;
    decoded.op = 4'd15;
    if (opcode == 6'h00) begin
      decLegal = 1'b1;
      case (funct)
        6'h20:   decoded.op = 4'd0;
        6'h21:   decoded.op = 4'd1;
        6'h22:   decoded.op = 4'd2;
        6'h23:   decoded.op = 4'd3;
        6'h24:   decoded.op = 4'd4;
        6'h27:   decoded.op = 4'd5;
        6'h25:   decoded.op = 4'd6;
        6'h26:   decoded.op = 4'd7;
        6'h00:   begin decoded.op = 4'd8;  shamtSel = 1'b1; end
        6'h04:   decoded.op = 4'd9;
        6'h02:   begin decoded.op = 4'd10; shamtSel = 1'b1; end
        6'h06:   decoded.op = 4'd11;
        6'h03:   begin decoded.op = 4'd12; shamtSel = 1'b1; end
        6'h07:   decoded.op = 4'd13;
        6'h2A:   decoded.op = 4'd14;
        default: decLegal = 1'b0;
      endcase
      if (decLegal) begin
        decoded.rega = shamtSel ? {27'b0, shamt} : bus.rs_data;
        decoded.regb = bus.rt_data;
        decoded.dest = bus.instr[15:11];
      end
    end else begin
      decLegal = 1'b1;
      case (opcode)
        6'h08:   begin decoded.op = 4'd0;  decoded.regb = immSext; end
        6'h09:   begin decoded.op = 4'd1;  decoded.regb = immSext; end
        6'h0A:   begin decoded.op = 4'd14; decoded.regb = immSext; end
        6'h0C:   begin decoded.op = 4'd4;  decoded.regb = immZext; end
        6'h0D:   begin decoded.op = 4'd6;  decoded.regb = immZext; end
        6'h0E:   begin decoded.op = 4'd7;  decoded.regb = immZext; end
        6'h0F:   begin decoded.op = 4'd8;  decoded.regb = immZext; isLui = 1'b1; end
        default: decLegal = 1'b0;
      endcase
      if (decLegal) begin
        decoded.rega = isLui ? 32'd16 : bus.rs_data;
        decoded.dest = bus.instr[20:16];
      end
    end
    decoded.illegal = ~decLegal;
  end

  payload_t   mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wrPtr_q, rdPtr_q;
  logic       push, pop;

  assign bus.in_ready  = (count_q != FullCount);
  assign bus.out_valid = (count_q != 2'd0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  // Flush clears only the occupancy; stale storage is never visible since outputs gate on out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wrPtr_q] <= decoded;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
    end
  end

  payload_t head;
  assign head = bus.out_valid ? mem_q[rdPtr_q] : '0;

  assign bus.rega       = head.rega;
  assign bus.regb       = head.regb;
  assign bus.alu_ctrl_s = head.op;
  assign bus.dest       = head.dest;
  assign bus.illegal    = head.illegal;

endmodule
